// File: rtl/naf_scalar_ctrl_if.sv
// Handshake bundle between the NAF scalar sequencer and its requester / EC arithmetic unit.
// The master side drives the request and op_ready; the slave side is the sequencer.
interface naf_scalar_ctrl_if;
   logic         start;
   logic [511:0] h;
   logic [31:0]  hlength;
   logic         busy;
   logic         op_valid;
   logic [2:0]   op_code;
   logic [7:0]   op_idx;
   logic         op_ready;
   logic         done;
   logic         zero_result;
   logic         digit_err;

   modport master (
      output start, h, hlength, op_ready,
      input  busy, op_valid, op_code, op_idx, done, zero_result, digit_err
   );

   modport slave (
      input  start, h, hlength, op_ready,
      output busy, op_valid, op_code, op_idx, done, zero_result, digit_err
   );
endinterface

// File: rtl/naf_scalar_ctrl.sv
// Walks a NAF-encoded scalar from its top digit downward and emits the
// LDP/LDN/DBL/ADD/SUB point-operation stream for a double-and-add multiplier.
module naf_scalar_ctrl #(
   parameter int HMAX = 255
) (
   input  logic            clk,
   input  logic            rst,
   naf_scalar_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      LOAD,
      DBL,
      ACC,
      FIN
   } state_t;

   localparam logic [2:0] OP_LDP = 3'b000;
   localparam logic [2:0] OP_LDN = 3'b001;
   localparam logic [2:0] OP_DBL = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;

   state_t       state_reg;
   logic [511:0] h_reg;
   logic [7:0]   idx_reg;
   logic         busy_reg;
   logic         op_valid_reg;
   logic [2:0]   op_code_reg;
   logic [7:0]   op_idx_reg;
   logic         done_reg;
   logic         zero_reg;
   logic         err_reg;

   logic [1:0]   digit [0:255];
   logic [1:0]   cur_digit;
   logic         cur_nz;
   logic         cur_bad;
   logic [7:0]   top_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 256; gi++) begin : g_digit
         assign digit[gi] = h_reg[2*gi+1 : 2*gi];
      end
   endgenerate

   // Bit 0 alone separates +1/-1 (01/11) from zero/invalid (00/10).
   assign cur_digit = digit[idx_reg];
   assign cur_nz    = cur_digit[0];
   assign cur_bad   = (cur_digit == 2'b10);
   assign top_sel   = (bus.hlength > 32'(HMAX)) ? 8'(HMAX) : bus.hlength[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         h_reg        <= '0;
         idx_reg      <= '0;
         busy_reg     <= 1'b0;
         op_valid_reg <= 1'b0;
         op_code_reg  <= '0;
         op_idx_reg   <= '0;
         done_reg     <= 1'b0;
         zero_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  h_reg     <= bus.h;
                  idx_reg   <= top_sel;
                  err_reg   <= 1'b0;
                  zero_reg  <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= SCAN;
               end
            end

            SCAN: begin
               if (cur_bad) begin
                  err_reg <= 1'b1;
               end
               if (cur_nz) begin
                  state_reg    <= LOAD;
                  op_valid_reg <= 1'b1;
                  op_code_reg  <= cur_digit[1] ? OP_LDN : OP_LDP;
                  op_idx_reg   <= idx_reg;
               end else if (idx_reg == 8'd0) begin
                  state_reg <= FIN;
                  done_reg  <= 1'b1;
                  zero_reg  <= 1'b1;
               end else begin
                  idx_reg <= idx_reg - 8'd1;
               end
            end

            LOAD, ACC: begin
               if (bus.op_ready) begin
                  if (idx_reg == 8'd0) begin
                     op_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                     state_reg    <= FIN;
                  end else begin
                     op_code_reg <= OP_DBL;
                     op_idx_reg  <= idx_reg - 8'd1;
                     idx_reg     <= idx_reg - 8'd1;
                     state_reg   <= DBL;
                  end
               end
            end

            // Digit j is inspected once its doubling has been accepted.
            DBL: begin
               if (bus.op_ready) begin
                  if (cur_bad) begin
                     err_reg <= 1'b1;
                  end
                  if (cur_nz) begin
                     op_code_reg <= cur_digit[1] ? OP_SUB : OP_ADD;
                     state_reg   <= ACC;
                  end else if (idx_reg == 8'd0) begin
                     op_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                     state_reg    <= FIN;
                  end else begin
                     op_idx_reg <= idx_reg - 8'd1;
                     idx_reg    <= idx_reg - 8'd1;
                  end
               end
            end

            FIN: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.op_valid    = op_valid_reg;
   assign bus.op_code     = op_code_reg;
   assign bus.op_idx      = op_idx_reg;
   assign bus.done        = done_reg;
   assign bus.zero_result = zero_reg;
   assign bus.digit_err   = err_reg;

endmodule

// File: tb/tb_naf_scalar_ctrl.sv
// Randomized bench for naf_scalar_ctrl: an op-list / scalar-value reference model
// built from the NAF digits is compared against the observed op handshakes.
module tb_naf_scalar_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   naf_scalar_ctrl_if bus();

   naf_scalar_ctrl #(.HMAX(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Handshake monitor: records accepted ops and checks hold-under-backpressure.
   logic [10:0] obs_q[$];
   logic        prev_stall = 1'b0;
   logic [2:0]  prev_code;
   logic [7:0]  prev_idx;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", bus.op_valid, 1'b1);
            check("hold_code", bus.op_code, prev_code);
            check("hold_idx", bus.op_idx, prev_idx);
         end
         if (bus.op_valid) check("valid_while_busy", bus.busy, 1'b1);
         if (bus.op_valid && bus.op_ready) obs_q.push_back({bus.op_code, bus.op_idx});
         prev_stall = bus.op_valid && !bus.op_ready;
         prev_code  = bus.op_code;
         prev_idx   = bus.op_idx;
      end
   end

   int stall_left;
   bit stalled_once;

   task automatic drive_ready(input int mode);
      if (mode == 2 && !stalled_once && bus.op_valid && bus.op_code == 3'b010) begin
         stall_left   = 5;
         stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
         bus.op_ready = 1'b0;
         stall_left--;
      end else if (mode == 1) begin
         bus.op_ready = 1'($urandom % 2);
      end else begin
         bus.op_ready = 1'b1;
      end
   endtask

   task automatic run_seq(input logic [511:0] hv, input logic [31:0] hl, input int mode,
                          input bit poke, input string name);
      logic [10:0]        exp_q[$];
      logic [1:0]         d;
      logic signed [263:0] one = 264'sd1;
      logic signed [263:0] exp_val = '0;
      logic signed [263:0] obs_val = '0;
      bit                 exp_err = 1'b0;
      bit                 got_done = 1'b0;
      int                 n = -1;
      int                 top;
      int                 cyc = 0;

      // Reference: digits top..0, value sum(d_j*2^j), op list of double-and-add.
      top = (hl > 32'd255) ? 255 : int'(hl);
      for (int j = top; j >= 0; j--) begin
         d = hv[2*j +: 2];
         if (d == 2'b10) exp_err = 1'b1;
         if (d == 2'b01) exp_val = exp_val + (one <<< j);
         if (d == 2'b11) exp_val = exp_val - (one <<< j);
         if (n < 0 && (d == 2'b01 || d == 2'b11)) n = j;
      end
      if (n >= 0) begin
         d = hv[2*n +: 2];
         exp_q.push_back({(d == 2'b01) ? 3'b000 : 3'b001, 8'(n)});
         for (int j = n - 1; j >= 0; j--) begin
            d = hv[2*j +: 2];
            exp_q.push_back({3'b010, 8'(j)});
            if (d == 2'b01) exp_q.push_back({3'b011, 8'(j)});
            if (d == 2'b11) exp_q.push_back({3'b100, 8'(j)});
         end
      end

      obs_q.delete();
      stall_left   = 0;
      stalled_once = 1'b0;
      bus.h       = hv;
      bus.hlength = hl;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      drive_ready(mode);

      while (!got_done && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            got_done = 1'b1;
         end else begin
            check({name, ":busy"}, bus.busy, 1'b1);
            @(posedge clk);
            #1;
            bus.start = poke && (cyc == 2);
            if (bus.start) begin
               bus.h       = ~hv;
               bus.hlength = 32'd7;
            end
            drive_ready(mode);
         end
      end
      bus.start = 1'b0;
      check({name, ":done_seen"}, got_done, 1'b1);
      check({name, ":zero_result"}, bus.zero_result, (n < 0));
      check({name, ":digit_err"}, bus.digit_err, exp_err);
      if (n < 0) check({name, ":scan_cycles"}, cyc - 1, top + 1);

      @(posedge clk);
      #1;
      @(negedge clk);
      check({name, ":done_pulse"}, bus.done, 1'b0);
      check({name, ":idle_busy"}, bus.busy, 1'b0);

      check({name, ":op_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s:op%0d", name, i), obs_q[i], exp_q[i]);
      end
      foreach (obs_q[i]) begin
         case (obs_q[i][10:8])
            3'b000:  obs_val = one;
            3'b001:  obs_val = -one;
            3'b010:  obs_val = obs_val <<< 1;
            3'b011:  obs_val = obs_val + one;
            3'b100:  obs_val = obs_val - one;
            default: obs_val = obs_val;
         endcase
      end
      if (n >= 0) check({name, ":q_value"}, obs_val, exp_val);
      $display("seq %s top=%0d ops=%0d/%0d zero=%0b err=%0b cycles=%0d",
               name, top, obs_q.size(), exp_q.size(), bus.zero_result, bus.digit_err, cyc);
   endtask

   function automatic logic [511:0] rand_h();
      logic [511:0] r;
      int           x;
      for (int j = 0; j < 256; j++) begin
         x = $urandom % 16;
         if (x < 9)       r[2*j +: 2] = 2'b00;
         else if (x < 12) r[2*j +: 2] = 2'b01;
         else if (x < 15) r[2*j +: 2] = 2'b11;
         else             r[2*j +: 2] = 2'b10;
      end
      return r;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ":busy"}, bus.busy, 1'b0);
      check({tag, ":op_valid"}, bus.op_valid, 1'b0);
      check({tag, ":op_code"}, bus.op_code, 3'b000);
      check({tag, ":op_idx"}, bus.op_idx, 8'd0);
      check({tag, ":done"}, bus.done, 1'b0);
      check({tag, ":zero_result"}, bus.zero_result, 1'b0);
      check({tag, ":digit_err"}, bus.digit_err, 1'b0);
   endtask

   initial begin
      logic [511:0] hv;
      logic [31:0]  hl;
      bit           found;

      bus.start    = 1'b0;
      bus.h        = '0;
      bus.hlength  = '0;
      bus.op_ready = 1'b1;
      rst = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      hv = '0; hv[1:0] = 2'b01;
      run_seq(hv, 32'd0, 0, 1'b0, "k1");
      hv = '0; hv[7:6] = 2'b01; hv[1:0] = 2'b11;
      run_seq(hv, 32'd3, 0, 1'b0, "k7");
      run_seq('0, 32'd5, 0, 1'b0, "zero5");
      hv = '0; hv[13:12] = 2'b01; hv[7:6] = 2'b11; hv[3:2] = 2'b01;
      run_seq(hv, 32'd6, 2, 1'b0, "backpressure");
      hv = '0; hv[5:4] = 2'b10; hv[9:8] = 2'b01;
      run_seq(hv, 32'd4, 0, 1'b0, "bad_digit");
      hv = rand_h(); hv[511:510] = 2'b01;
      run_seq(hv, 32'd300, 1, 1'b1, "hlen300_poke");

      // Asynchronous reset while an ADD/SUB is being presented.
      hv = '0; hv[21:20] = 2'b01; hv[17:16] = 2'b11; hv[5:4] = 2'b01;
      bus.h = hv; bus.hlength = 32'd10; bus.start = 1'b1; bus.op_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (bus.op_valid && (bus.op_code == 3'b011 || bus.op_code == 3'b100)) found = 1'b1;
      end
      check("acc_reached", found, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rst_in_acc");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      repeat (4) begin
         @(negedge clk);
         check("post_rst_valid", bus.op_valid, 1'b0);
         check("post_rst_busy", bus.busy, 1'b0);
      end
      check("post_rst_no_ops", obs_q.size(), 0);

      // Start presented in the very first cycle after reset release.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hv = '0; hv[9:8] = 2'b11; hv[1:0] = 2'b01;
      run_seq(hv, 32'd4, 0, 1'b0, "start_after_rst");

      for (int t = 0; t < 40; t++) begin
         hv = rand_h();
         case ($urandom % 8)
            0:       hl = 32'd300 + ($urandom % 1000);
            1:       hl = $urandom;
            default: hl = $urandom_range(0, 40);
         endcase
         if ($urandom % 6 == 0) hv = '0;
         run_seq(hv, hl, int'($urandom % 3), (hl >= 32'd5), $sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/naf_scalar_ctrl.md
NAF_SCALAR_CTRL -- requirements
Module: naf_scalar_ctrl

Interface
REQ-001 SHALL have parameter HMAX, default 255, meaning the highest NAF digit index scanned (256 digits in a 512-bit h).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to sequence a NAF word; sampled only in IDLE.
REQ-005 SHALL have port h  input  512  NAF digits, little-endian, 2 bits per digit, digit j = h[2j+1:2j]: 00=0, 01=+1, 11=-1, 10=invalid.
REQ-006 SHALL have port hlength  input  32  index of the most significant digit to scan.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port op_valid  output  1  point-operation request to the EC arithmetic unit.
REQ-009 SHALL have port op_code  output  3  000=LDP (Q=P), 001=LDN (Q=-P), 010=DBL (Q=2Q), 011=ADD (Q=Q+P), 100=SUB (Q=Q-P).
REQ-010 SHALL have port op_idx  output  8  digit index the current op belongs to.
REQ-011 SHALL have port op_ready  input  1  arithmetic unit accepts the op when op_valid and op_ready are both high.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port zero_result  output  1  valid with done; high when all scanned digits are zero (Q = infinity).
REQ-014 SHALL have port digit_err  output  1  valid with done; high if any scanned digit was 10.

Function
REQ-015 SHALL implement states IDLE, SCAN, LOAD, DBL, ACC, FIN.
REQ-016 SHALL, in IDLE with start=1, latch h and min(hlength, HMAX) into internal registers, clear the error/zero flags, and enter SCAN; start outside IDLE SHALL be ignored.
REQ-017 SHALL, in SCAN, examine one digit per cycle from the latched top index downward; digits 00 and 10 are zero (10 sets digit_err sticky).
REQ-018 SHALL, on the first nonzero digit j in SCAN, enter LOAD presenting LDP (01) or LDN (11) with op_idx=j.
REQ-019 SHALL, if SCAN finishes digit 0 with no nonzero digit found, enter FIN with zero_result=1 and issue no op.
REQ-020 SHALL, after each accepted LOAD/ACC op at index j>0, enter DBL with op_idx=j-1; after an accepted op at index 0, enter FIN.
REQ-021 SHALL, after an accepted DBL at index j, enter ACC presenting ADD (01) or SUB (11) with op_idx=j if digit j is nonzero, else continue to DBL at j-1 or to FIN if j=0.
REQ-022 SHALL hold op_valid, op_code, op_idx stable until the handshake; op_valid SHALL drop the cycle after acceptance unless the next op is presented immediately.
REQ-023 SHALL assert op_valid only in LOAD, DBL, ACC.
REQ-024 SHALL, in FIN, assert done for exactly one cycle with zero_result and digit_err valid, then return to IDLE.
REQ-025 SHALL produce ops whose sequential execution yields Q = sum(d_j * 2^j) * P.

Reset
REQ-026 SHALL, on rst, asynchronously force state IDLE and busy, op_valid, op_code, op_idx, done, zero_result, digit_err and all internal registers to 0.
REQ-027 SHALL abort any sequence in progress on rst mid-operation, issue no further ops, and accept start on the first cycle after rst deasserts.

Verification
REQ-028 SHALL cover k=1: h digit0=01, hlength=0, op_ready=1 -> single LDP idx0, then done=1, zero_result=0.
REQ-029 SHALL cover k=7: digit3=01, digit0=11, hlength=3 -> LDP3, DBL2, DBL1, DBL0, SUB0, done.
REQ-030 SHALL cover h=0, hlength=5 -> no op_valid, done with zero_result=1 after 6 SCAN cycles.
REQ-031 SHALL cover backpressure: op_ready low 5 cycles during DBL -> op_valid/op_code/op_idx constant, sequence resumes unchanged.
REQ-032 SHALL cover digit 10 at index 2 with digit4=01, hlength=4 -> treated as zero, ops LDP4, DBL3, DBL2, DBL1, DBL0, digit_err=1 at done.
REQ-033 SHALL cover rst during ACC, start while busy, and hlength=300 -> all outputs 0 after reset, start ignored while busy, scan begins at index 255.
